// File: rtl/riscv_isa.sv
//------------------------------------------------------------------------------
// Module : riscv_isa (package)
// Brief  : ALU opcodes, issue-bundle layout and FSM states for the exec pipe.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package riscv_isa;

    localparam int ALU_OP_W = 4;
    localparam int XLEN     = 32;
    localparam int PREG_AW  = 7;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } alu_op_e;

    // Field order is MSB-first; exec_p0 slices its flat port in the same order.
    typedef struct packed {
        alu_op_e              alu_op;
        logic [PREG_AW-1:0]   rd;
        logic [XLEN-1:0]      data_a;
        logic [XLEN-1:0]      data_b;
    } instruction_flow_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } exec_state_e;

endpackage

`default_nettype wire

// File: rtl/mul_serial.sv
//------------------------------------------------------------------------------
// Module : mul_serial
// Brief  : Shift-add multiplier, one multiplier bit per cycle, low-half product.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mul_serial #(
    parameter int DWIDTH     = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [DWIDTH-1:0] a_i,
    input  logic [DWIDTH-1:0] b_i,
    output logic              done_o,
    output logic [DWIDTH-1:0] product_o
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    logic [DWIDTH-1:0] mcand_q, mcand_d;
    logic [DWIDTH-1:0] mplier_q, mplier_d;
    logic [DWIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;

    // done_o flags the cycle doing the final iteration; product_o is valid next cycle.
    assign done_o    = busy_q && (cnt_q == CNT_W'(MUL_CYCLES - 1));
    assign product_o = acc_q;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (done_o) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/exec_p0.sv
//------------------------------------------------------------------------------
// Module : exec_p0
// Brief  : Execution port 0 - single-cycle ALU plus serial multiplier with FSM.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module exec_p0
    import riscv_isa::*;
#(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 7,
    parameter int MUL_CYCLES = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [ALU_OP_W+AWIDTH+2*DWIDTH-1:0]    instruction_i,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    output logic [DWIDTH-1:0]                      write_data,
    output logic [AWIDTH-1:0]                      write_addr,
    output logic                                   write_valid
);

    localparam int INSTR_W = ALU_OP_W + AWIDTH + 2 * DWIDTH;

    alu_op_e           op;
    logic [AWIDTH-1:0] rd;
    logic [DWIDTH-1:0] data_a;
    logic [DWIDTH-1:0] data_b;
    logic [4:0]        shamt;

    assign op     = alu_op_e'(instruction_i[INSTR_W-1 -: ALU_OP_W]);
    assign rd     = instruction_i[2*DWIDTH +: AWIDTH];
    assign data_a = instruction_i[DWIDTH +: DWIDTH];
    assign data_b = instruction_i[0 +: DWIDTH];
    assign shamt  = data_b[4:0];

    exec_state_e       state_q, state_d;
    logic [AWIDTH-1:0] rd_q, rd_d;
    logic [DWIDTH-1:0] write_data_q, write_data_d;
    logic [AWIDTH-1:0] write_addr_q, write_addr_d;
    logic              write_valid_q, write_valid_d;

    logic [DWIDTH-1:0] alu_result;
    logic              alu_known;
    logic              mul_start;
    logic              mul_done;
    logic [DWIDTH-1:0] mul_product;

    always_comb begin
        alu_result = '0;
        alu_known  = 1'b1;
        case (op)
            OP_ADD:  alu_result = data_a + data_b;
            OP_SUB:  alu_result = data_a - data_b;
            OP_AND:  alu_result = data_a & data_b;
            OP_OR:   alu_result = data_a | data_b;
            OP_XOR:  alu_result = data_a ^ data_b;
            OP_SLL:  alu_result = data_a << shamt;
            OP_SRL:  alu_result = data_a >> shamt;
            OP_SRA:  alu_result = $signed(data_a) >>> shamt;
            OP_SLT:  alu_result = {{(DWIDTH-1){1'b0}}, ($signed(data_a) < $signed(data_b))};
            OP_SLTU: alu_result = {{(DWIDTH-1){1'b0}}, (data_a < data_b)};
            default: alu_known  = 1'b0;
        endcase
    end

    mul_serial #(
        .DWIDTH     (DWIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (mul_start),
        .a_i       (data_a),
        .b_i       (data_b),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Result registers only move on a real write, so they hold otherwise.
    always_comb begin
        state_d       = state_q;
        rd_d          = rd_q;
        write_data_d  = write_data_q;
        write_addr_d  = write_addr_q;
        write_valid_d = 1'b0;
        mul_start     = 1'b0;
        ready_o       = (state_q == S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    if (op == OP_MUL) begin
                        mul_start = 1'b1;
                        rd_d      = rd;
                        state_d   = S_MUL;
                    end else if (alu_known && (rd != '0)) begin
                        write_valid_d = 1'b1;
                        write_data_d  = alu_result;
                        write_addr_d  = rd;
                    end
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (rd_q != '0) begin
                    write_valid_d = 1'b1;
                    write_data_d  = mul_product;
                    write_addr_d  = rd_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rd_q          <= '0;
            write_data_q  <= '0;
            write_addr_q  <= '0;
            write_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_q          <= rd_d;
            write_data_q  <= write_data_d;
            write_addr_q  <= write_addr_d;
            write_valid_q <= write_valid_d;
        end
    end

    assign write_data  = write_data_q;
    assign write_addr  = write_addr_q;
    assign write_valid = write_valid_q;

endmodule

`default_nettype wire

// File: doc/exec_p0.md
EXEC_P0 -- requirements
Module: exec_p0

Interface
REQ-001 Parameter DWIDTH, default 32, SHALL set the operand and result width.
REQ-002 Parameter AWIDTH, default 7, SHALL set the physical-register address width (128 registers).
REQ-003 Parameter MUL_CYCLES, default 32, SHALL set the iteration count of the multiplier.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be asynchronous and active-high.
REQ-006 instruction_i  input  INSTRUCTION_FLOW  SHALL carry the issued instruction: alu_op, rd, data_a, data_b.
REQ-007 valid_i  input  1  SHALL qualify instruction_i.
REQ-008 ready_o  output  1  SHALL indicate that a new instruction is accepted this cycle.
REQ-009 write_data  output  DWIDTH  SHALL be the result to the regbank write port.
REQ-010 write_addr  output  AWIDTH  SHALL be the destination physical register.
REQ-011 write_valid  output  1  SHALL qualify write_data and write_addr for exactly one cycle per result.

Function
REQ-012 An instruction SHALL be accepted when valid_i and ready_o are both 1 on a rising edge.
REQ-013 The FSM SHALL have three states: IDLE, MUL and DONE.
REQ-014 In IDLE, ready_o SHALL be 1. In MUL and DONE, ready_o SHALL be 0.
REQ-015 The single-cycle ops SHALL be ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT and SLTU.
REQ-016 A single-cycle op SHALL assert write_valid on the edge after acceptance; the state SHALL remain IDLE, so one op per cycle is sustainable back-to-back.
REQ-017 Shift ops SHALL use data_b[4:0] only.
REQ-018 SLT SHALL compare as signed; SLTU SHALL compare as unsigned; both SHALL produce 0 or 1.
REQ-019 ADD and SUB SHALL wrap modulo 2^DWIDTH; no overflow flag.
REQ-020 On accepting MUL, the FSM SHALL go IDLE->MUL and latch the operands and rd.
REQ-021 MUL SHALL use shift-add, one bit per cycle, for MUL_CYCLES cycles, and return the low DWIDTH bits of the product.
REQ-022 On the final iteration, the FSM SHALL go MUL->DONE. DONE SHALL assert write_valid for one cycle and then go to IDLE.
REQ-023 MUL latency SHALL be MUL_CYCLES+1 cycles from acceptance to write_valid (33 at default).
REQ-024 valid_i while ready_o=0 SHALL be ignored. The upstream holds the instruction; it is neither lost nor duplicated.
REQ-025 If rd==0, write_valid SHALL stay 0 but the timing SHALL be unchanged.
REQ-026 An unknown alu_op SHALL produce result 0 with write_valid suppressed.
REQ-027 When write_valid is 0, write_data and write_addr SHALL hold their previous values.

Reset
REQ-028 Asserting reset SHALL immediately force state=IDLE, write_valid=0, write_data=0, write_addr=0 and iteration counter=0.
REQ-029 Reset during MUL SHALL abandon the operation; no write_valid SHALL be emitted afterward.
REQ-030 ready_o SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-031 The ALU op enum and INSTRUCTION_FLOW SHALL live in the shared package riscv_isa.
REQ-032 The iterative multiplier SHALL be a sub-module named mul_serial with start/done handshake.
REQ-033 The FSM and single-cycle ALU SHALL remain in exec_p0.

Verification
REQ-034 Scenario: ADD 5+7, rd=3 -> next edge write_valid=1, write_data=12, write_addr=3.
REQ-035 Scenario: SUB 4-5 -> write_data=0xFFFFFFFF. SLT(0xFFFFFFFF,1) -> 1. SLTU(0xFFFFFFFF,1) -> 0.
REQ-036 Scenario: SRA 0x80000000 by 36 (uses 4) -> 0xF8000000. SRL of the same -> 0x08000000.
REQ-037 Scenario: MUL 7*6, rd=9 -> ready_o=0 for 33 cycles; write_valid=1 once, write_data=42, write_addr=9. A valid_i held during MUL is accepted only after return to IDLE.
REQ-038 Scenario: four back-to-back ADDs with rd=1..4 -> four consecutive write_valid cycles with matching addresses. Repeat with rd=0 -> no write_valid.
REQ-039 Scenario: reset asserted 10 cycles into a MUL -> write_valid stays 0. The next ADD 1+1 yields 2 one cycle after acceptance.
